// File: rtl/lynx_vram_pkg.sv
// lynx_vram_pkg: shared types and defaults for the VRAM bank arbiter.
//   VRAM_AW / VRAM_DW : default VRAM address / data widths
//   vram_arb_state_t  : arbiter FSM state
//   is_slot_state()   : states in which the next RAM slot is chosen
package lynx_vram_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        VID_ISS,
        VID_DAT,
        CPU_ISS,
        CPU_DAT
    } vram_arb_state_t;

    // A new slot may start after the data phase of the previous access,
    // so the RAM is kept busy every cycle under load.
    function automatic logic is_slot_state(input vram_arb_state_t s);
        return (s == IDLE) || (s == VID_DAT) || (s == CPU_DAT);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the video fetch, CPU bus and RAM-side signals of
// one VRAM bank arbiter.
//   slave  : the arbiter (takes requests, drives RAM and responses)
//   master : the surrounding system (video path, CPU decode, RAM model)
interface vram_arbiter_if
    import lynx_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_do;
    logic          vid_valid;
    logic          vid_ovf;
    logic          blank;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_di;
    logic [DW-1:0] cpu_do;
    logic          cpu_ack;
    logic          cpu_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    modport slave (
        input  vid_req, vid_addr, blank, cpu_req, cpu_we, cpu_addr, cpu_di, ram_do,
        output vid_do, vid_valid, vid_ovf, cpu_do, cpu_ack, cpu_wait,
               ram_addr, ram_we, ram_di
    );

    modport master (
        output vid_req, vid_addr, blank, cpu_req, cpu_we, cpu_addr, cpu_di, ram_do,
        input  vid_do, vid_valid, vid_ovf, cpu_do, cpu_ack, cpu_wait,
               ram_addr, ram_we, ram_di
    );

endinterface

// File: rtl/vram_fetch_latch.sv
// vram_fetch_latch: holds one pending video fetch until the arbiter issues it.
//   clock, reset : system clock, async active-high reset
//   vid_req      : one-cycle fetch strobe; vid_addr sampled with it
//   take         : arbiter is issuing the fetch this cycle
//   fetch_valid  : a fetch is pending (latched or arriving now)
//   fetch_addr   : address to fetch (newest request wins)
//   ovf          : sticky, a request arrived while one was still latched
module vram_fetch_latch
    import lynx_vram_pkg::*;
#(
    parameter int AW = VRAM_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          take,
    output logic          fetch_valid,
    output logic [AW-1:0] fetch_addr,
    output logic          ovf
);
    logic          pending;
    logic [AW-1:0] addr_q;

    // A strobe arriving in a slot cycle is forwarded straight to the issue
    // logic, so an idle bus issues it on the very next edge.
    assign fetch_valid = pending | vid_req;
    assign fetch_addr  = vid_req ? vid_addr : addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            addr_q  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (vid_req && pending)
                ovf <= 1'b1;
            if (take) begin
                pending <= 1'b0;
            end else if (vid_req) begin
                pending <= 1'b1;
                addr_q  <= vid_addr;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM bank between video
// fetches (priority, bounded latency) and Z80 cycles (stretched via WAIT).
//   clock, reset : system clock, async active-high reset
//   bus          : vram_arbiter_if.slave (video, CPU and RAM-side signals)
// Build option: VRAM_ARB_BLANK_ONLY_EN admits the CPU only while blank=1;
// without it the CPU may use any slot video does not claim.
module vram_arbiter
    import lynx_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input logic           clock,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    vram_arb_state_t state;

    logic          fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic          vid_ovf;
    logic          slot;
    logic          take;
    logic          cpu_ok;
    logic          cpu_go;
    logic          done;
    logic          cpu_wr_q;
    logic [DW-1:0] vid_do_q;
    logic [DW-1:0] cpu_do_q;
    logic [DW-1:0] ram_di_q;
    logic [AW-1:0] ram_addr_q;
    logic          vid_valid_q;
    logic          cpu_ack_q;
    logic          ram_we_q;

    vram_fetch_latch #(.AW(AW)) u_fetch_latch (
        .clock       (clock),
        .reset       (reset),
        .vid_req     (bus.vid_req),
        .vid_addr    (bus.vid_addr),
        .take        (take),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .ovf         (vid_ovf)
    );

`ifdef VRAM_ARB_BLANK_ONLY_EN
    assign cpu_ok = bus.blank;
`else
    assign cpu_ok = 1'b1;
`endif

    assign slot = is_slot_state(state);
    assign take = slot & fetch_valid;
    // CPU_DAT completes the current access; its done flag is only visible
    // next cycle, so the same request must not be re-granted from here.
    assign cpu_go = slot & ~fetch_valid & (state != CPU_DAT)
                  & bus.cpu_req & ~done & cpu_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vid_do_q    <= '0;
            vid_valid_q <= 1'b0;
            cpu_do_q    <= '1;
            cpu_ack_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            done        <= 1'b0;
            cpu_wr_q    <= 1'b0;
        end else begin
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ram_we_q    <= 1'b0;

            if (!bus.cpu_req)
                done <= 1'b0;

            case (state)
                VID_ISS: state <= VID_DAT;
                CPU_ISS: state <= CPU_DAT;
                default: state <= take ? VID_ISS : (cpu_go ? CPU_ISS : IDLE);
            endcase

            // RAM data for the issued address is on ram_do during *_DAT.
            if (state == VID_DAT) begin
                vid_do_q    <= bus.ram_do;
                vid_valid_q <= 1'b1;
            end
            if (state == CPU_DAT) begin
                if (!cpu_wr_q)
                    cpu_do_q <= bus.ram_do;
                cpu_ack_q <= 1'b1;
                // A request already withdrawn must not block its successor.
                done      <= bus.cpu_req;
            end

            if (take) begin
                ram_addr_q <= fetch_addr;
            end else if (cpu_go) begin
                ram_addr_q <= bus.cpu_addr;
                ram_we_q   <= bus.cpu_we;
                ram_di_q   <= bus.cpu_di;
                cpu_wr_q   <= bus.cpu_we;
            end
        end
    end

    assign bus.vid_do    = vid_do_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_ovf   = vid_ovf;
    assign bus.cpu_do    = cpu_do_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_wait  = bus.cpu_req & ~done & ~cpu_ack_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_di    = ram_di_q;

endmodule
